// File: rtl/uartb_fifo_core.sv
// UART core: one TX engine with single-byte or burst writes, one RX engine
// with a 2-flop synchronizer and start-bit mid-sampling, and a first-word
// fall-through RX FIFO with sticky framing-error and overrun flags.
module uartb_fifo_core #(
    parameter int DATA_W   = 32,
    parameter int BRG_W    = 16,
    parameter int RX_DEPTH = 8,
    parameter int DIV_RST  = 7
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DATA_W-1:0]           d,
    input  logic                        wrtx,
    input  logic                        wrbaud,
    input  logic                        rxd,
    input  logic                        rd,
    output logic                        txd,
    output logic [7:0]                  q,
    output logic                        dv,
    output logic                        txbusy,
    output logic [$clog2(RX_DEPTH):0]   rxcount,
    output logic                        ferr,
    output logic                        ovf
);

    localparam int NB  = DATA_W / 8;
    localparam int AW  = $clog2(RX_DEPTH);
    localparam int CW  = AW + 1;
    localparam int TBW = $clog2(NB + 1);
    localparam logic [TBW-1:0] TX_NB   = TBW'(NB);
    localparam logic [TBW-1:0] TX_ONE  = TBW'(1);
    localparam logic [CW-1:0]  FIFO_FULL = CW'(RX_DEPTH);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;

    // Configuration
    logic [BRG_W-1:0]  div_q;
    logic              mode_q;
    logic [BRG_W-1:0]  div_eff;
    logic [BRG_W-1:0]  rx_half_m1;

    // TX engine
    tx_state_t         tx_state_q;
    logic [DATA_W-1:0] tx_shift_q;
    logic [TBW-1:0]    tx_left_q;
    logic [BRG_W-1:0]  tx_cnt_q;
    logic [2:0]        tx_bit_q;
    logic              txd_q;
    logic              txbusy_q;

    // RX engine
    logic              rx_sync1_q;
    logic              rx_sync2_q;
    logic              rx_prev_q;
    rx_state_t         rx_state_q;
    logic [BRG_W-1:0]  rx_cnt_q;
    logic [2:0]        rx_bit_q;
    logic [7:0]        rx_shift_q;
    logic              rx_push_q;
    logic [7:0]        rx_byte_q;
    logic              rx_ferr_set_q;

    // RX FIFO
    logic [7:0]        mem_q [RX_DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [CW-1:0]     count_q;
    logic [CW-1:0]     count_d;
    logic              pop;
    logic              push_ok;
    logic              ovf_set;
    logic              flag_clr;

    // Flags
    logic              ferr_q;
    logic              ovf_q;

    // Divider and burst-mode configuration register
    // NOTE: sequential state is always written with non-blocking assignments so
    // every flop samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q  <= BRG_W'(DIV_RST);
            mode_q <= 1'b0;
        end else if (wrbaud) begin
            div_q  <= d[BRG_W-1:0];
            mode_q <= d[DATA_W-1];
        end
    end

    // Effective divider (0 behaves as 1) and half-bit offset for start sampling
    // NOTE: every combinational output gets a default assignment first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        div_eff    = div_q;
        if (div_q == '0) begin
            div_eff = BRG_W'(1);
        end
        // (div+1)/2 clocks to the start sample equals a reload of (div-1)/2
        rx_half_m1 = (div_eff - BRG_W'(1)) >> 1;
    end

    // TX FSM: start, 8 data bits LSB first, stop; repeats for remaining burst bytes
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= TX_IDLE;
            tx_shift_q <= '0;
            tx_left_q  <= '0;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            txd_q      <= 1'b1;
            txbusy_q   <= 1'b0;
        end else begin
            case (tx_state_q)
                TX_IDLE: begin
                    if (wrtx) begin
                        tx_shift_q <= d;
                        tx_left_q  <= mode_q ? TX_NB : TX_ONE;
                        tx_cnt_q   <= div_eff;
                        tx_state_q <= TX_START;
                        txd_q      <= 1'b0;
                        txbusy_q   <= 1'b1;
                    end
                end
                default: begin
                    if (tx_cnt_q != '0) begin
                        tx_cnt_q <= tx_cnt_q - BRG_W'(1);
                    end else begin
                        tx_cnt_q <= div_eff;
                        case (tx_state_q)
                            TX_START: begin
                                tx_state_q <= TX_DATA;
                                tx_bit_q   <= 3'd0;
                                txd_q      <= tx_shift_q[0];
                            end
                            TX_DATA: begin
                                // Shift after every bit; after the 8th the next byte sits at [7:0]
                                tx_shift_q <= tx_shift_q >> 1;
                                if (tx_bit_q == 3'd7) begin
                                    tx_state_q <= TX_STOP;
                                    txd_q      <= 1'b1;
                                end else begin
                                    tx_bit_q <= tx_bit_q + 3'd1;
                                    txd_q    <= tx_shift_q[1];
                                end
                            end
                            default: begin
                                if (tx_left_q == TX_ONE) begin
                                    tx_state_q <= TX_IDLE;
                                    txbusy_q   <= 1'b0;
                                end else begin
                                    tx_left_q  <= tx_left_q - TX_ONE;
                                    tx_state_q <= TX_START;
                                    txd_q      <= 1'b0;
                                end
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    // Two-flop synchronizer for rxd plus one delayed copy for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_sync1_q <= 1'b1;
            rx_sync2_q <= 1'b1;
            rx_prev_q  <= 1'b1;
        end else begin
            rx_sync1_q <= rxd;
            rx_sync2_q <= rx_sync1_q;
            rx_prev_q  <= rx_sync2_q;
        end
    end

    // RX FSM: detect falling edge, confirm start mid-bit, sample 8 data bits and stop
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_q    <= RX_IDLE;
            rx_cnt_q      <= '0;
            rx_bit_q      <= '0;
            rx_shift_q    <= '0;
            rx_push_q     <= 1'b0;
            rx_byte_q     <= '0;
            rx_ferr_set_q <= 1'b0;
        end else begin
            rx_push_q     <= 1'b0;
            rx_ferr_set_q <= 1'b0;
            case (rx_state_q)
                RX_IDLE: begin
                    if (rx_prev_q && !rx_sync2_q) begin
                        rx_state_q <= RX_START;
                        rx_cnt_q   <= rx_half_m1;
                    end
                end
                RX_WAIT: begin
                    if (rx_sync2_q) begin
                        rx_state_q <= RX_IDLE;
                    end
                end
                default: begin
                    if (rx_cnt_q != '0) begin
                        rx_cnt_q <= rx_cnt_q - BRG_W'(1);
                    end else begin
                        rx_cnt_q <= div_eff;
                        case (rx_state_q)
                            RX_START: begin
                                // A high line at mid-start is a glitch: re-arm silently
                                if (rx_sync2_q) begin
                                    rx_state_q <= RX_IDLE;
                                end else begin
                                    rx_state_q <= RX_DATA;
                                    rx_bit_q   <= 3'd0;
                                end
                            end
                            RX_DATA: begin
                                rx_shift_q <= {rx_sync2_q, rx_shift_q[7:1]};
                                if (rx_bit_q == 3'd7) begin
                                    rx_state_q <= RX_STOP;
                                end else begin
                                    rx_bit_q <= rx_bit_q + 3'd1;
                                end
                            end
                            default: begin
                                if (rx_sync2_q) begin
                                    rx_push_q  <= 1'b1;
                                    rx_byte_q  <= rx_shift_q;
                                    rx_state_q <= RX_IDLE;
                                end else begin
                                    rx_ferr_set_q <= 1'b1;
                                    rx_state_q    <= RX_WAIT;
                                end
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    // FIFO handshake: a pop frees the slot a simultaneous push then fills
    always_comb begin
        pop     = rd && (count_q != '0);
        push_ok = rx_push_q && ((count_q != FIFO_FULL) || pop);
        ovf_set = rx_push_q && (count_q == FIFO_FULL) && !pop;
        count_d = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push_ok) begin
            count_d = count_q - CW'(1);
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at RX_DEPTH
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
        end
    end

    // FIFO storage
    // NOTE: the data array has no reset; contents are only observable while
    // count_q says they are valid, so clearing them would buy nothing.
    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            mem_q[wr_ptr_q] <= rx_byte_q;
        end
    end

    // Sticky error flags; a new error in the clearing cycle wins over the clear
    always_ff @(posedge clk) begin
        if (rst) begin
            ferr_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            if (rx_ferr_set_q) begin
                ferr_q <= 1'b1;
            end else if (flag_clr) begin
                ferr_q <= 1'b0;
            end
            if (ovf_set) begin
                ovf_q <= 1'b1;
            end else if (flag_clr) begin
                ovf_q <= 1'b0;
            end
        end
    end

    assign flag_clr = wrbaud && d[DATA_W-2];

    assign txd     = txd_q;
    assign txbusy  = txbusy_q;
    assign q       = mem_q[rd_ptr_q];
    assign dv      = (count_q != '0);
    assign rxcount = count_q;
    assign ferr    = ferr_q;
    assign ovf     = ovf_q;

endmodule
